seg7_display_ctrl: RTL and testbench

//  Parametrised multi-digit seven-segment display controller; successor to the fixed 8x hexdriver fan-out.

---
 rtl/seg7_display_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_display_ctrl
// Brief    : Multi-digit seven-segment controller with leading-zero blanking,
//            per-digit blink and optional binary-to-decimal display
//            (enabled by defining SEG7_DEC_MODE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_display_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int DATA_W         = 32,
    parameter int BLINK_DIV      = 25_000_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    dec_mode,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic                    busy,
    output logic                    ovf,
    output logic [7*NUM_DIGITS-1:0] seg
);
    localparam int HEX_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [7*NUM_DIGITS-1:0] SEG_BLANK = {(7*NUM_DIGITS){SEG_ACTIVE_LOW}};

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   phase_q, phase_d;
    logic [HEX_W-1:0]       disp_q, disp_d;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic                   w_dash;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        hex_glyph = 7'h00;
        case (n)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            4'hF: hex_glyph = 7'h71;
            default: hex_glyph = 7'h00;
        endcase
    endfunction

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

`ifdef SEG7_DEC_MODE_EN
    // Enough BCD digits to hold any DATA_W-bit value (0.31 > log10(2)).
    localparam int BCD_DIGITS = (DATA_W * 31) / 100 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int SH_W       = $clog2(DATA_W + 1);
    localparam logic [SH_W-1:0] SH_LAST = SH_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, w_bcd_adj;
    logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              dash_q, dash_d;
    logic              w_bcd_ovf;

    assign w_bcd_ovf = |bcd_q[BCD_W-1:HEX_W];

    always_comb begin
        w_bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        sh_cnt_d = sh_cnt_q;
        busy_d   = busy_q;
        ovf_d    = ovf_q;
        dash_d   = dash_q;
        disp_d   = disp_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    if (dec_mode) begin
                        state_d  = ST_SHIFT;
                        bin_d    = wr_data;
                        bcd_d    = '0;
                        sh_cnt_d = '0;
                        busy_d   = 1'b1;
                    end else begin
                        disp_d = wr_data[HEX_W-1:0];
                        ovf_d  = 1'b0;
                        dash_d = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                bcd_d    = {w_bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
                bin_d    = {bin_q[DATA_W-2:0], 1'b0};
                sh_cnt_d = sh_cnt_q + SH_W'(1);
                if (sh_cnt_q == SH_LAST) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                disp_d  = bcd_q[HEX_W-1:0];
                ovf_d   = w_bcd_ovf;
                dash_d  = w_bcd_ovf;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            sh_cnt_q <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dash_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            sh_cnt_q <= sh_cnt_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            dash_q   <= dash_d;
        end
    end

    assign busy   = busy_q;
    assign ovf    = ovf_q;
    assign w_dash = dash_q;
`else
    logic w_unused_inputs;

    assign w_unused_inputs = dec_mode ^ (^wr_data);

    always_comb begin
        disp_d = disp_q;
        if (wr_en) begin
            disp_d = wr_data[HEX_W-1:0];
        end
    end

    assign busy   = 1'b0;
    assign ovf    = 1'b0;
    assign w_dash = 1'b0;
`endif

    // Scan from the top digit so 'seen' marks everything at or below the MSD.
    always_comb begin
        logic       seen;
        logic       blank;
        logic [3:0] nib;
        logic [6:0] glyph;
        seen  = 1'b0;
        blank = 1'b0;
        nib   = 4'h0;
        glyph = 7'h00;
        seg_d = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib   = disp_q[4*i +: 4];
            seen  = seen | (nib != 4'h0);
            blank = (phase_q & blink_mask[i])
                  | (lz_blank & ~seen & ~w_dash & (i != 0));
            glyph = blank ? 7'h00 : (w_dash ? 7'h40 : hex_glyph(nib));
            seg_d[7*i +: 7] = SEG_ACTIVE_LOW ? ~glyph : glyph;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            disp_q  <= '0;
            seg_q   <= SEG_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
        end
    end

    assign seg = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
`default_nettype none
// Testbench for seg7_display_ctrl: randomized stimulus against a cycle-level
// behavioural model of the display value, blink phase and decimal conversion.
module tb_seg7_display_ctrl;
    localparam int NUM_DIGITS = 8;
    localparam int DATA_W     = 32;
    localparam int BLINK_DIV  = 4;
`ifdef SEG7_DEC_MODE_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        dec_mode;
    logic        lz_blank;
    logic [7:0]  blink_mask;
    logic        busy;
    logic        ovf;
    logic [55:0] seg;

    seg7_display_ctrl #(
        .NUM_DIGITS    (NUM_DIGITS),
        .DATA_W        (DATA_W),
        .BLINK_DIV     (BLINK_DIV),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .dec_mode  (dec_mode),
        .lz_blank  (lz_blank),
        .blink_mask(blink_mask),
        .busy      (busy),
        .ovf       (ovf),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Active-high glyphs, bit0 = a .. bit6 = g.
    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [31:0] m_val;
    bit          m_dash;
    bit          m_ovf;
    int          m_busy_cnt;
    logic [31:0] m_pend_val;
    bit          m_pend_dash;
    int          m_edges;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [55:0] model_seg();
        logic [55:0] s;
        logic [6:0]  g;
        logic [3:0]  nib;
        int          msd;
        bit          phase;
        msd   = 0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (((m_val >> (4*i)) & 32'hF) != 0) msd = i;
        phase = ((m_edges / BLINK_DIV) % 2) == 1;
        s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = 4'((m_val >> (4*i)) & 32'hF);
            g   = m_dash ? 7'h40 : glyph_tab[nib];
            if (phase && blink_mask[i]) g = 7'h00;
            if (lz_blank && !m_dash && i > msd) g = 7'h00;
            s[7*i +: 7] = ~g;
        end
        return s;
    endfunction

    task automatic to_decimal(input logic [31:0] v_in);
        longint v;
        v = longint'(v_in);
        m_pend_val = '0;
        if (v >= 64'd100_000_000) begin
            m_pend_dash = 1'b1;
        end else begin
            m_pend_dash = 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                m_pend_val = m_pend_val | (32'(v % 10) << (4*i));
                v = v / 10;
            end
        end
    endtask

    // Advance one clock: predict, step the model, then compare after the edge.
    task automatic tick();
        logic [55:0] e_seg;
        bit          accept;
        e_seg = rst ? model_seg() : {56{1'b1}};
        if (!rst) begin
            m_val = '0; m_dash = 1'b0; m_ovf = 1'b0; m_busy_cnt = 0; m_edges = 0;
        end else begin
            accept = wr_en && (m_busy_cnt == 0);
            m_edges++;
            if (m_busy_cnt > 0) begin
                m_busy_cnt--;
                if (m_busy_cnt == 0) begin
                    m_val  = m_pend_dash ? 32'h0 : m_pend_val;
                    m_dash = m_pend_dash;
                    m_ovf  = m_pend_dash;
                end
            end
            if (accept) begin
                if (DEC_EN && dec_mode) begin
                    m_busy_cnt = DATA_W + 1;
                    to_decimal(wr_data);
                end else begin
                    m_val = wr_data; m_dash = 1'b0; m_ovf = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("seg", 64'(seg), 64'(e_seg));
        chk("busy", 64'(busy), 64'(m_busy_cnt > 0));
        chk("ovf", 64'(ovf), 64'(m_ovf));
    endtask

    task automatic write(input logic [31:0] d, input logic dm);
        wr_en = 1'b1; wr_data = d; dec_mode = dm;
        tick();
        wr_en = 1'b0; dec_mode = 1'b0;
    endtask

    initial begin
        int blen;
        rst = 1'b0; wr_en = 1'b0; wr_data = '0; dec_mode = 1'b0;
        lz_blank = 1'b0; blink_mask = '0;
        m_val = '0; m_dash = 1'b0; m_ovf = 1'b0; m_busy_cnt = 0; m_edges = 0;
        m_pend_val = '0; m_pend_dash = 1'b0;

        tick(); tick();
        chk("reset_blank", 64'(seg), 64'({8{7'h7F}}));
        rst = 1'b1;
        tick();
        chk("release_zero", 64'(seg), 64'({8{7'h40}}));

        write(32'h1F00_0001, 1'b0);
        tick();
        chk("hex_1F000001", 64'(seg), 64'({7'h79, 7'h0E, {5{7'h40}}, 7'h79}));
        lz_blank = 1'b1;
        write(32'h1F00_0001, 1'b0);
        tick();
        chk("hex_lz_same", 64'(seg), 64'({7'h79, 7'h0E, {5{7'h40}}, 7'h79}));
        write(32'h0, 1'b0);
        tick();
        chk("hex_zero_lz", 64'(seg), 64'({{7{7'h7F}}, 7'h40}));

        lz_blank = 1'b0; blink_mask = 8'h01;
        write(32'h1, 1'b0);
        for (int i = 0; i < 16; i++) tick();
        blink_mask = 8'h00;

`ifdef SEG7_DEC_MODE_EN
        write(32'd42, 1'b1);
        blen = busy ? 1 : 0;
        for (int g = 0; g < 100 && busy; g++) begin
            tick();
            if (busy) blen++;
        end
        chk("busy_len", 64'(blen), 64'd33);
        tick();
        chk("dec_42", 64'(seg), 64'({{6{7'h40}}, 7'h19, 7'h24}));
        lz_blank = 1'b1;
        tick();
        chk("dec_42_lz", 64'(seg), 64'({{6{7'h7F}}, 7'h19, 7'h24}));
        lz_blank = 1'b0;

        write(32'd123456789, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        write(32'h5, 1'b0);
        for (int i = 0; i < 30; i++) tick();
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_dash", 64'(seg), 64'({8{7'h3F}}));

        write(32'd77, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b0;
        tick();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_blank", 64'(seg), 64'({8{7'h7F}}));
        rst = 1'b1;
        tick();
        chk("abort_zero", 64'(seg), 64'({8{7'h40}}));
        for (int i = 0; i < 40; i++) tick();
`else
        blen = 0;
        write(32'h0000_0042, 1'b1);
        tick();
        chk("decoff_hex", 64'(seg), 64'({{6{7'h40}}, 7'h19, 7'h24}));
        chk("decoff_busy", 64'(busy) + 64'(blen), 64'd0);
`endif

        for (int i = 0; i < 2500; i++) begin
            rst      = ($urandom_range(0, 299) != 0);
            wr_en    = ($urandom_range(0, 9) == 0);
            wr_data  = $urandom >> (4 * $urandom_range(0, 8));
            dec_mode = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 99) == 0) blink_mask = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
